// File: rtl/useq_pkg.sv
// Shared definitions for the multiplier micro-sequencer:
// branch codes, micro-addresses, control bits, microword layout.
package useq_pkg;

    localparam int ADDR_W = 3;
    localparam int CTRL_W = 7;
    localparam int UW_W   = 14;

    typedef enum logic [1:0] {
        SEQ = 2'b00,
        JMP = 2'b01,
        BRZ = 2'b10,
        WST = 2'b11
    } cond_e;

    localparam logic [ADDR_W-1:0] UA_IDLE  = 3'd0;
    localparam logic [ADDR_W-1:0] UA_LDM   = 3'd1;
    localparam logic [ADDR_W-1:0] UA_LDQ   = 3'd2;
    localparam logic [ADDR_W-1:0] UA_TEST  = 3'd3;
    localparam logic [ADDR_W-1:0] UA_ADD   = 3'd4;
    localparam logic [ADDR_W-1:0] UA_ACC   = 3'd5;
    localparam logic [ADDR_W-1:0] UA_OUT   = 3'd6;
    localparam logic [ADDR_W-1:0] UA_SPARE = 3'd7;

    localparam int CB_OUT  = 0;
    localparam int CB_LDM  = 1;
    localparam int CB_CLRR = 2;
    localparam int CB_ADD  = 3;
    localparam int CB_DECQ = 4;
    localparam int CB_LDR  = 5;
    localparam int CB_LDQ  = 6;

    localparam int UW_TGT_LSB  = 0;
    localparam int UW_COND_LSB = 3;
    localparam int UW_DONE     = 5;
    localparam int UW_BSEL     = 6;
    localparam int UW_CTRL_LSB = 7;

    // Field order matches {ctrl, bus_sel, done, cond, target}
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              bsel;
        logic              done;
        cond_e             cond;
        logic [ADDR_W-1:0] tgt;
    } uword_t;

endpackage

// File: rtl/useq_if.sv
// Sequencer-side bundle: host handshake, datapath flag,
// control word and debug micro-address.
interface useq_if
    import useq_pkg::*;
();

    logic              start;
    logic              z_nz;
    logic [CTRL_W-1:0] control;
    logic              bus_sel;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] upc;

    modport master (
        input  start,
        input  z_nz,
        output control,
        output bus_sel,
        output busy,
        output done,
        output upc
    );

    modport slave (
        output start,
        output z_nz,
        input  control,
        input  bus_sel,
        input  busy,
        input  done,
        input  upc
    );

endinterface

// File: rtl/useq_rom.sv
// Combinational control store for the repeated-addition
// multiply microprogram.
module useq_rom
    import useq_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output uword_t            uw
);

    always_comb begin
        uw = '{ctrl: '0, bsel: 1'b0, done: 1'b0,
               cond: JMP, tgt: UA_IDLE};
        case (addr)
            UA_IDLE: begin
                uw.cond = WST;
            end
            UA_LDM: begin
                uw.ctrl = 7'b0000110;
                uw.cond = SEQ;
            end
            UA_LDQ: begin
                uw.ctrl = 7'b1000000;
                uw.bsel = 1'b1;
                uw.cond = SEQ;
            end
            UA_TEST: begin
                uw.cond = BRZ;
                uw.tgt  = UA_OUT;
            end
            UA_ADD: begin
                uw.ctrl = 7'b0001000;
                uw.cond = SEQ;
            end
            UA_ACC: begin
                uw.ctrl = 7'b0110000;
                uw.tgt  = UA_TEST;
            end
            UA_OUT: begin
                uw.ctrl = 7'b0000001;
                uw.done = 1'b1;
            end
            default: begin
                uw.tgt = UA_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/useq_control.sv
// Microprogrammed sequencer: upc register, next-address
// logic and control-word decode for the multiplier datapath.
module useq_control
    import useq_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    useq_if.master  bus
);

    logic [ADDR_W-1:0] upc;
    logic [ADDR_W-1:0] upc_nxt;
    logic [ADDR_W-1:0] upc_inc;
    uword_t            uw;

    useq_rom u_rom (
        .addr (upc),
        .uw   (uw)
    );

    assign upc_inc = upc + ADDR_W'(1);

    always_comb begin
        upc_nxt = upc_inc;
        unique case (uw.cond)
            SEQ: upc_nxt = upc_inc;
            JMP: upc_nxt = uw.tgt;
            BRZ: upc_nxt = bus.z_nz ? upc_inc : uw.tgt;
            WST: upc_nxt = bus.start ? upc_inc : upc;
            default: upc_nxt = UA_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc <= UA_IDLE;
        end else begin
            upc <= upc_nxt;
        end
    end

    // Outputs decode only the word at upc, never start/z_nz
    assign bus.control = uw.ctrl;
    assign bus.bus_sel = uw.bsel;
    assign bus.done    = uw.done;
    assign bus.busy    = (upc != UA_IDLE);
    assign bus.upc     = upc;

endmodule

// File: tb/tb_useq_control.sv
// Self-checking bench: sequencer driving a behavioural 4-bit
// repeated-addition datapath, checked against cycle/result rules.
module tb_useq_control;
    import useq_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    useq_if bus ();

    useq_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0] op_m = '0;
    logic [3:0] op_b = '0;
    logic [3:0] m_r  = '0;
    logic [3:0] q_r  = '0;
    logic [3:0] r_r  = '0;
    logic [3:0] a_r  = '0;
    logic [3:0] din;
    logic [3:0] dout;

    assign din      = bus.bus_sel ? op_b : op_m;
    assign dout     = bus.control[CB_OUT] ? r_r : 4'd0;
    assign bus.z_nz = (q_r != 4'd0);

    always @(posedge clk) begin
        if (bus.control[CB_LDM])  m_r <= din;
        if (bus.control[CB_CLRR]) r_r <= 4'd0;
        else if (bus.control[CB_LDR]) r_r <= a_r;
        if (bus.control[CB_ADD])  a_r <= r_r + m_r;
        if (bus.control[CB_LDQ])  q_r <= din;
        else if (bus.control[CB_DECQ]) q_r <= q_r - 4'd1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic run_mul(input logic [3:0] m, input logic [3:0] b,
                           input bit noise);
        int lim;
        int done_k;
        int n_done;
        int n_busy;
        int outv;
        lim    = 4 + 3 * int'(b);
        done_k = -1;
        n_done = 0;
        n_busy = 0;
        outv   = -1;
        @(negedge clk);
        op_m = m;
        op_b = b;
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= lim + 3; k++) begin
            @(negedge clk);
            if (k == 1) chk("bus_sel_c1", bus.bus_sel, 0);
            if (k == 2) chk("bus_sel_c2", bus.bus_sel, 1);
            bus.start = (noise && k < lim) ? 1'($urandom % 2) : 1'b0;
            if (bus.busy) n_busy++;
            if (bus.done) begin
                n_done++;
                done_k = k;
                outv   = int'(dout);
            end
        end
        chk("done_cycle", done_k, lim);
        chk("done_count", n_done, 1);
        chk("result", outv, (int'(m) * int'(b)) % 16);
        chk("busy_cycles", n_busy, lim);
    endtask

    task automatic run_b2b(input logic [3:0] m, input logic [3:0] b);
        int lim;
        int dq[$];
        int rq[$];
        int bound;
        lim = 4 + 3 * int'(b);
        @(negedge clk);
        op_m = m;
        op_b = b;
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 2 * lim + 2; k++) begin
            @(negedge clk);
            if (k == lim + 1) chk("b2b_idle_gap", int'(bus.upc), 0);
            if (k == lim + 2) chk("b2b_restart", int'(bus.upc), 1);
            if (bus.done) begin
                dq.push_back(k);
                rq.push_back(int'(dout));
            end
        end
        bus.start = 1'b0;
        chk("b2b_ndone", dq.size(), 2);
        if (dq.size() == 2) begin
            chk("b2b_done1", dq[0], lim);
            chk("b2b_done2", dq[1], 2 * lim + 1);
            chk("b2b_res2", rq[1], (int'(m) * int'(b)) % 16);
        end
        bound = 0;
        while (bus.upc != 3'd0 && bound < 80) begin
            @(negedge clk);
            bound++;
        end
        chk("b2b_drain", int'(bus.busy), 0);
    endtask

    initial begin
        int bound;
        int n_done;
        int bad;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("rst_upc", int'(bus.upc), 0);
        chk("rst_control", int'(bus.control), 0);
        chk("rst_bus_sel", int'(bus.bus_sel), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        n_done = 0;
        bad    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.upc != 3'd0 || bus.control != 7'd0) bad++;
            if (bus.done) n_done++;
        end
        chk("idle_hold", bad, 0);
        chk("idle_done", n_done, 0);

        run_mul(4'd3, 4'd4, 1'b0);
        run_mul(4'd9, 4'd0, 1'b0);
        run_mul(4'd5, 4'd5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_mul(4'($urandom % 16), 4'($urandom % 16), 1'b1);
        end

        run_b2b(4'd2, 4'd3);

        @(negedge clk);
        op_m = 4'd7;
        op_b = 4'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bound = 0;
        while (bus.upc != 3'd4 && bound < 40) begin
            @(negedge clk);
            bound++;
        end
        chk("mid_reach_add", int'(bus.upc), 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_upc", int'(bus.upc), 0);
        chk("mid_rst_control", int'(bus.control), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_mul(4'd6, 4'd2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
